reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries.
REQ-002 SHALL have parameter PREG_W, default 5, physical register tag width.
REQ-003 SHALL have one clock and reset: clk_i in 1, rising-edge clock; reset_i in 1, synchronous, active-high.
REQ-004 SHALL have these dispatch ports:
- disp_valid_i in 1: renamed instruction offered.
- disp_ready_o out 1: entry available.
- disp_pc_i in 32; disp_inst_i in 32.
- disp_prs1_i in PREG_W; disp_prs1_rdy_i in 1: source 1 tag and ready flag.
- disp_prs2_i in PREG_W; disp_prs2_rdy_i in 1: source 2 tag and ready flag.
- disp_prd_i in PREG_W: destination tag.
REQ-005 SHALL have these wakeup ports: cdb_en_i in 1; cdb_reg_addr_i in PREG_W, broadcast tag.
REQ-006 SHALL have these issue ports:
- issue_valid_o out 1; issue_ready_i in 1: functional-unit accept.
- issue_pc_o out 32; issue_inst_o out 32.
- issue_prs1_o, issue_prs2_o, issue_prd_o out PREG_W each.
REQ-007 SHALL have flush_i in 1 (discard all entries) and count_o out $clog2(DEPTH+1) (occupied entries).

Function
REQ-008 SHALL store entries age-ordered: index 0 oldest, occupied entries contiguous from index 0.
REQ-009 SHALL perform dispatch when disp_valid_i && disp_ready_o, writing the entry at index count_o, or count_o-1 if an issue fires in the same cycle.
REQ-010 SHALL drive disp_ready_o = (count_o < DEPTH) from registered state only, with no combinational path from issue_ready_i; a full station that issues SHALL NOT accept dispatch in that cycle.
REQ-011 SHALL treat tag 0 as always ready: a source tag of 0 is stored ready regardless of its rdy flag.
REQ-012 SHALL, on cdb_en_i, set the ready bit of every stored source whose tag equals cdb_reg_addr_i, effective at the next edge.
REQ-013 SHALL bypass same-cycle wakeup at dispatch: a dispatching source whose tag equals cdb_reg_addr_i while cdb_en_i is high SHALL be stored ready.
REQ-014 SHALL select for issue, combinationally, the lowest-index valid entry with both sources ready (oldest-ready).
REQ-015 SHALL drive issue_valid_o high iff such an entry exists; issue_* fields SHALL come from that entry.
REQ-016 SHALL complete an issue on issue_valid_o && issue_ready_i, removing the entry at the edge and shifting higher entries down one index, preserving order and ready bits.
REQ-017 SHALL allow a stalled selection (issue_ready_i low) to change to an older entry that becomes ready; the interface SHALL NOT require stability.
REQ-018 SHALL apply latency as follows:
- Dispatch with both sources ready -> issue_valid_o earliest in the next cycle.
- CDB wakeup at edge N -> issue eligible in cycle N+1.
REQ-019 SHALL apply a CDB broadcast in the same cycle as a shift to the post-shift entries, so no wakeup is lost.
REQ-020 SHALL give flush_i priority over dispatch and issue bookkeeping: at the next edge all entries are invalid and count_o=0.
REQ-021 SHALL ignore dispatch while full and ignore issue_ready_i while issue_valid_o is low; neither SHALL corrupt state.

Reset
REQ-022 SHALL, while reset_i is high at an edge, clear all valid and ready bits and set count_o=0.
REQ-023 SHALL hold disp_ready_o=0 while reset_i is high and drive it 1 in the first cycle after reset_i falls.
REQ-024 SHALL hold issue_valid_o=0 from reset until a ready entry exists; reset mid-operation SHALL discard all entries with no issue.

Structure
REQ-025 SHALL place DEPTH, PREG_W and entry field widths in the shared processor parameter package/header also used by the rename and decode stages.
REQ-026 SHALL implement oldest-ready selection in one sub-module, rs_select (ready-vector in, one-hot grant plus index out).

Verification
REQ-027 SHALL cover back-to-back dispatch: 4 dispatches, all sources ready, issue_ready_i=1 -> issues in dispatch order, one per cycle, starting the cycle after the first dispatch.
REQ-028 SHALL cover wakeup: dispatch prs1=7 not ready; cdb_en_i=1, cdb_reg_addr_i=7 two cycles later -> issue_valid_o=1 the next cycle, issue_prs1_o=7.
REQ-029 SHALL cover the dispatch bypass: dispatch prs2=9 not ready while cdb_en_i=1 with tag 9 -> the entry issues the next cycle.
REQ-030 SHALL cover out-of-order issue: entry0 waits on tag 3, entry1 ready -> entry1 issues first, entry0 shifts and stays, then issues after CDB tag 3.
REQ-031 SHALL cover full plus simultaneous events: fill 4 entries, then issue_ready_i=1 with disp_valid_i=1 -> no dispatch that cycle, count_o 4->3, disp_ready_o=1 the next cycle.
REQ-032 SHALL cover flush and reset mid-operation: flush_i or reset_i with 3 entries -> count_o=0 and issue_valid_o=0 the next cycle, and the concurrent dispatch is discarded.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared processor parameters used by rename, decode and the reservation station.
// Holds default station geometry, tag and word widths, and small sizing helpers.
package reservation_station_pkg;

    localparam int RS_DEPTH  = 4;
    localparam int RS_PREG_W = 5;
    localparam int XLEN      = 32;

    typedef logic [XLEN-1:0] word_t;

    // Index width that stays legal for a single-entry structure.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Oldest-ready picker: lowest set bit of the request vector wins.
// Produces a one-hot grant, the encoded index and an any-request flag.
module rs_select
    import reservation_station_pkg::*;
#(
    parameter int N = RS_DEPTH
)(
    input  logic [N-1:0]            req,
    output logic [N-1:0]            grant,
    output logic [idx_width(N)-1:0] grant_idx,
    output logic                    grant_any
);

    localparam int IW = idx_width(N);

    // Scan from the top so the last hit, the lowest index, is kept.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
            end
        end
    end

    assign grant_any = |req;

endmodule

// File: rtl/reservation_station.sv
// Age-ordered reservation station: contiguous entries from index 0 (oldest),
// CDB wakeup with dispatch bypass, oldest-ready issue with compacting shift.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH  = RS_DEPTH,
    parameter int PREG_W = RS_PREG_W
)(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         disp_valid_i,
    output logic                         disp_ready_o,
    input  logic [31:0]                  disp_pc_i,
    input  logic [31:0]                  disp_inst_i,
    input  logic [PREG_W-1:0]            disp_prs1_i,
    input  logic                         disp_prs1_rdy_i,
    input  logic [PREG_W-1:0]            disp_prs2_i,
    input  logic                         disp_prs2_rdy_i,
    input  logic [PREG_W-1:0]            disp_prd_i,
    input  logic                         cdb_en_i,
    input  logic [PREG_W-1:0]            cdb_reg_addr_i,
    output logic                         issue_valid_o,
    input  logic                         issue_ready_i,
    output logic [31:0]                  issue_pc_o,
    output logic [31:0]                  issue_inst_o,
    output logic [PREG_W-1:0]            issue_prs1_o,
    output logic [PREG_W-1:0]            issue_prs2_o,
    output logic [PREG_W-1:0]            issue_prd_o,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = idx_width(DEPTH);

    word_t             pc_reg    [DEPTH];
    word_t             inst_reg  [DEPTH];
    logic [PREG_W-1:0] prs1_reg  [DEPTH];
    logic [PREG_W-1:0] prs2_reg  [DEPTH];
    logic [PREG_W-1:0] prd_reg   [DEPTH];
    logic              rdy1_reg  [DEPTH];
    logic              rdy2_reg  [DEPTH];

    word_t             pc_next   [DEPTH];
    word_t             inst_next [DEPTH];
    logic [PREG_W-1:0] prs1_next [DEPTH];
    logic [PREG_W-1:0] prs2_next [DEPTH];
    logic [PREG_W-1:0] prd_next  [DEPTH];
    logic              rdy1_next [DEPTH];
    logic              rdy2_next [DEPTH];

    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W-1:0]  wr_idx;
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  req;
    logic [DEPTH-1:0]  grant;
    logic [DEPTH-1:0]  shift_mask;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic              issue_fire;
    logic              disp_fire;
    logic              disp_rdy1;
    logic              disp_rdy2;

    function automatic logic wake(input logic [PREG_W-1:0] tag, input logic rdy,
                                  input logic en, input logic [PREG_W-1:0] addr);
        return rdy || (en && (tag == addr));
    endfunction

    // Readiness depends only on registered count, never on issue_ready_i.
    assign disp_ready_o  = !reset_i && (count_reg < CNT_W'(DEPTH));
    assign disp_fire     = disp_valid_i && disp_ready_o;
    assign issue_valid_o = sel_any && !reset_i;
    assign issue_fire    = issue_valid_o && issue_ready_i;
    assign wr_idx        = issue_fire ? count_reg - CNT_W'(1) : count_reg;
    assign count_o       = count_reg;

    assign disp_rdy1 = (disp_prs1_i == '0) ||
                       wake(disp_prs1_i, disp_prs1_rdy_i, cdb_en_i, cdb_reg_addr_i);
    assign disp_rdy2 = (disp_prs2_i == '0) ||
                       wake(disp_prs2_i, disp_prs2_rdy_i, cdb_en_i, cdb_reg_addr_i);

    always_comb begin
        count_next = count_reg;
        if (issue_fire) begin
            count_next = count_next - CNT_W'(1);
        end
        if (disp_fire) begin
            count_next = count_next + CNT_W'(1);
        end
    end

    rs_select #(
        .N (DEPTH)
    ) u_select (
        .req       (req),
        .grant     (grant),
        .grant_idx (sel_idx),
        .grant_any (sel_any)
    );

    // Entries at or above the issuing one move down by one slot.
    always_comb begin
        logic acc;
        acc        = 1'b0;
        shift_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            acc           = acc | grant[i];
            shift_mask[i] = acc && issue_fire;
        end
    end

    assign issue_pc_o   = pc_reg[sel_idx];
    assign issue_inst_o = inst_reg[sel_idx];
    assign issue_prs1_o = prs1_reg[sel_idx];
    assign issue_prs2_o = prs2_reg[sel_idx];
    assign issue_prd_o  = prd_reg[sel_idx];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam int SRC_UP = (gi + 1 < DEPTH) ? gi + 1 : gi;

        logic              load;
        logic [PREG_W-1:0] src_prs1;
        logic [PREG_W-1:0] src_prs2;
        logic              src_rdy1;
        logic              src_rdy2;

        assign valid[gi] = CNT_W'(gi) < count_reg;
        assign req[gi]   = valid[gi] && rdy1_reg[gi] && rdy2_reg[gi];
        assign load      = disp_fire && (wr_idx == CNT_W'(gi));

        assign src_prs1 = shift_mask[gi] ? prs1_reg[SRC_UP] : prs1_reg[gi];
        assign src_prs2 = shift_mask[gi] ? prs2_reg[SRC_UP] : prs2_reg[gi];
        assign src_rdy1 = shift_mask[gi] ? rdy1_reg[SRC_UP] : rdy1_reg[gi];
        assign src_rdy2 = shift_mask[gi] ? rdy2_reg[SRC_UP] : rdy2_reg[gi];

        // Wakeup is applied to the post-shift contents so no broadcast is lost.
        assign pc_next[gi]   = load ? disp_pc_i   :
                               (shift_mask[gi] ? pc_reg[SRC_UP] : pc_reg[gi]);
        assign inst_next[gi] = load ? disp_inst_i :
                               (shift_mask[gi] ? inst_reg[SRC_UP] : inst_reg[gi]);
        assign prd_next[gi]  = load ? disp_prd_i  :
                               (shift_mask[gi] ? prd_reg[SRC_UP] : prd_reg[gi]);
        assign prs1_next[gi] = load ? disp_prs1_i : src_prs1;
        assign prs2_next[gi] = load ? disp_prs2_i : src_prs2;
        assign rdy1_next[gi] = load ? disp_rdy1 :
                               wake(src_prs1, src_rdy1, cdb_en_i, cdb_reg_addr_i);
        assign rdy2_next[gi] = load ? disp_rdy2 :
                               wake(src_prs2, src_rdy2, cdb_en_i, cdb_reg_addr_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdy1_reg[i] <= 1'b0;
                rdy2_reg[i] <= 1'b0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                rdy1_reg[i] <= rdy1_next[i];
                rdy2_reg[i] <= rdy2_next[i];
            end
        end
    end

    // Payload is qualified by count and ready bits, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            pc_reg[i]   <= pc_next[i];
            inst_reg[i] <= inst_next[i];
            prs1_reg[i] <= prs1_next[i];
            prs2_reg[i] <= prs2_next[i];
            prd_reg[i]  <= prd_next[i];
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Scenario bench for reservation_station: per-feature tasks plus an issue
// scoreboard that pops expected entries whenever an issue handshake occurs.
module tb_reservation_station;

    localparam int DEPTH  = 4;
    localparam int PREG_W = 5;
    localparam int CNT_W  = 3;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              disp_valid_i;
    logic              disp_ready_o;
    logic [31:0]       disp_pc_i;
    logic [31:0]       disp_inst_i;
    logic [PREG_W-1:0] disp_prs1_i;
    logic              disp_prs1_rdy_i;
    logic [PREG_W-1:0] disp_prs2_i;
    logic              disp_prs2_rdy_i;
    logic [PREG_W-1:0] disp_prd_i;
    logic              cdb_en_i;
    logic [PREG_W-1:0] cdb_reg_addr_i;
    logic              issue_valid_o;
    logic              issue_ready_i;
    logic [31:0]       issue_pc_o;
    logic [31:0]       issue_inst_o;
    logic [PREG_W-1:0] issue_prs1_o;
    logic [PREG_W-1:0] issue_prs2_o;
    logic [PREG_W-1:0] issue_prd_o;
    logic              flush_i;
    logic [CNT_W-1:0]  count_o;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [PREG_W-1:0] prd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    reservation_station #(
        .DEPTH  (DEPTH),
        .PREG_W (PREG_W)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_pc_i       (disp_pc_i),
        .disp_inst_i     (disp_inst_i),
        .disp_prs1_i     (disp_prs1_i),
        .disp_prs1_rdy_i (disp_prs1_rdy_i),
        .disp_prs2_i     (disp_prs2_i),
        .disp_prs2_rdy_i (disp_prs2_rdy_i),
        .disp_prd_i      (disp_prd_i),
        .cdb_en_i        (cdb_en_i),
        .cdb_reg_addr_i  (cdb_reg_addr_i),
        .issue_valid_o   (issue_valid_o),
        .issue_ready_i   (issue_ready_i),
        .issue_pc_o      (issue_pc_o),
        .issue_inst_o    (issue_inst_o),
        .issue_prs1_o    (issue_prs1_o),
        .issue_prs2_o    (issue_prs2_o),
        .issue_prd_o     (issue_prd_o),
        .flush_i         (flush_i),
        .count_o         (count_o)
    );

    // Scoreboard: every handshake must match the oldest pending expectation.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (issue_valid_o === 1'b1 && issue_ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got pc=%h, required no issue", issue_pc_o);
            end else begin
                e = exp_q.pop_front();
                if ({issue_pc_o, issue_inst_o, issue_prs1_o, issue_prs2_o, issue_prd_o} !== e) begin
                    errors++;
                    $display("FAIL issue_fields: got pc=%h inst=%h prs1=%0d prs2=%0d prd=%0d, required pc=%h inst=%h prs1=%0d prs2=%0d prd=%0d",
                             issue_pc_o, issue_inst_o, issue_prs1_o, issue_prs2_o, issue_prd_o,
                             e.pc, e.inst, e.prs1, e.prs2, e.prd);
                end else begin
                    $display("issue    pc=%h prs1=%0d prs2=%0d prd=%0d", issue_pc_o,
                             issue_prs1_o, issue_prs2_o, issue_prd_o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        disp_valid_i    = 1'b0;
        disp_pc_i       = '0;
        disp_inst_i     = '0;
        disp_prs1_i     = '0;
        disp_prs1_rdy_i = 1'b0;
        disp_prs2_i     = '0;
        disp_prs2_rdy_i = 1'b0;
        disp_prd_i      = '0;
        cdb_en_i        = 1'b0;
        cdb_reg_addr_i  = '0;
        flush_i         = 1'b0;
    endtask

    task automatic drive_disp(input logic [31:0] pc, input logic [PREG_W-1:0] p1, input logic r1,
                              input logic [PREG_W-1:0] p2, input logic r2, input logic [PREG_W-1:0] prd,
                              input bit expect_issue);
        exp_t e;
        disp_valid_i    = 1'b1;
        disp_pc_i       = pc;
        disp_inst_i     = pc ^ 32'h5a5a_0000;
        disp_prs1_i     = p1;
        disp_prs1_rdy_i = r1;
        disp_prs2_i     = p2;
        disp_prs2_rdy_i = r2;
        disp_prd_i      = prd;
        $display("dispatch pc=%h prs1=%0d/%0b prs2=%0d/%0b prd=%0d", pc, p1, r1, p2, r2, prd);
        if (expect_issue) begin
            e = '{pc: pc, inst: pc ^ 32'h5a5a_0000, prs1: p1, prs2: p2, prd: prd};
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        issue_ready_i = 1'b0;
        idle();
        tick();
        tick();
        @(negedge clk_i);
        checks++; if (disp_ready_o !== 1'b0) begin errors++; $display("FAIL reset_disp_ready: got %b want 0", disp_ready_o); end
        checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
        tick();
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++; if (disp_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_disp_ready: got %b want 1", disp_ready_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive_disp(32'h100 + k * 4, 5'(k + 1), 1'b1, 5'(k + 20), 1'b1, 5'(k + 10), 1'b1);
            else idle();
            @(negedge clk_i);
            checks++;
            if (issue_valid_o !== (k > 0)) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, issue_valid_o, k > 0); end
            if (k > 0) begin
                checks++;
                if (issue_pc_o !== 32'h100 + (k - 1) * 4) begin
                    errors++; $display("FAIL b2b_order[%0d]: got pc=%h want %h", k, issue_pc_o, 32'h100 + (k - 1) * 4);
                end
            end
            tick();
        end
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL b2b_drain_count: got %0d want 0", count_o); end
        tick();
    endtask

    task automatic test_wakeup();
        issue_ready_i = 1'b1;
        drive_disp(32'h200, 5'd7, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
        @(negedge clk_i);
        tick();
        idle();
        cdb_en_i = 1'b1;
        cdb_reg_addr_i = 5'd8;
        @(negedge clk_i);
        checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL wake_early: got %b want 0", issue_valid_o); end
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL wake_count: got %0d want 1", count_o); end
        tick();
        cdb_reg_addr_i = 5'd7;
        @(negedge clk_i);
        checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL wake_wrong_tag: got %b want 0", issue_valid_o); end
        tick();
        idle();
        @(negedge clk_i);
        checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL wake_valid: got %b want 1", issue_valid_o); end
        checks++; if (issue_prs1_o !== 5'd7) begin errors++; $display("FAIL wake_prs1: got %0d want 7", issue_prs1_o); end
        tick();
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL wake_drain: got %0d want 0", count_o); end
        tick();
    endtask

    task automatic test_bypass();
        issue_ready_i = 1'b1;
        drive_disp(32'h300, 5'd4, 1'b1, 5'd9, 1'b0, 5'd13, 1'b1);
        cdb_en_i = 1'b1;
        cdb_reg_addr_i = 5'd9;
        @(negedge clk_i);
        tick();
        idle();
        @(negedge clk_i);
        checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", issue_valid_o); end
        checks++; if (issue_prs2_o !== 5'd9) begin errors++; $display("FAIL bypass_prs2: got %0d want 9", issue_prs2_o); end
        tick();
    endtask

    task automatic test_out_of_order();
        issue_ready_i = 1'b1;
        drive_disp(32'h400, 5'd3, 1'b0, 5'd5, 1'b1, 5'd14, 1'b0);
        tick();
        drive_disp(32'h404, 5'd6, 1'b1, 5'd0, 1'b1, 5'd15, 1'b1);
        exp_q.push_back('{pc: 32'h400, inst: 32'h400 ^ 32'h5a5a_0000, prs1: 5'd3, prs2: 5'd5, prd: 5'd14});
        @(negedge clk_i);
        checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_blocked: got %b want 0", issue_valid_o); end
        tick();
        idle();
        @(negedge clk_i);
        checks++; if (issue_pc_o !== 32'h404) begin errors++; $display("FAIL ooo_young_first: got pc=%h want 404", issue_pc_o); end
        tick();
        cdb_en_i = 1'b1;
        cdb_reg_addr_i = 5'd3;
        @(negedge clk_i);
        checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_old_waits: got %b want 0", issue_valid_o); end
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL ooo_count: got %0d want 1", count_o); end
        tick();
        idle();
        @(negedge clk_i);
        checks++; if (issue_pc_o !== 32'h400 || issue_valid_o !== 1'b1) begin errors++; $display("FAIL ooo_old_issue: got pc=%h valid=%b want 400/1", issue_pc_o, issue_valid_o); end
        tick();
    endtask

    task automatic test_shift_wakeup();
        issue_ready_i = 1'b0;
        drive_disp(32'h500, 5'd1, 1'b1, 5'd2, 1'b1, 5'd16, 1'b1);
        tick();
        drive_disp(32'h504, 5'd6, 1'b0, 5'd2, 1'b1, 5'd17, 1'b1);
        tick();
        idle();
        issue_ready_i = 1'b1;
        cdb_en_i = 1'b1;
        cdb_reg_addr_i = 5'd6;
        @(negedge clk_i);
        tick();
        idle();
        @(negedge clk_i);
        checks++; if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h504) begin errors++; $display("FAIL shift_wake: got valid=%b pc=%h want 1/504", issue_valid_o, issue_pc_o); end
        tick();
        issue_ready_i = 1'b0;
    endtask

    task automatic test_stall_reselect();
        issue_ready_i = 1'b0;
        drive_disp(32'h600, 5'd2, 1'b0, 5'd0, 1'b1, 5'd18, 1'b1);
        tick();
        drive_disp(32'h604, 5'd1, 1'b1, 5'd1, 1'b1, 5'd19, 1'b1);
        tick();
        idle();
        cdb_en_i = 1'b1;
        cdb_reg_addr_i = 5'd2;
        @(negedge clk_i);
        checks++; if (issue_pc_o !== 32'h604) begin errors++; $display("FAIL stall_young: got pc=%h want 604", issue_pc_o); end
        tick();
        idle();
        issue_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (issue_pc_o !== 32'h600) begin errors++; $display("FAIL stall_reselect: got pc=%h want 600", issue_pc_o); end
        tick();
        tick();
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL stall_drain: got %0d want 0", count_o); end
        tick();
        issue_ready_i = 1'b0;
    endtask

    task automatic test_full();
        issue_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_disp(32'h700 + k * 4, 5'(k + 1), 1'b1, 5'(k + 2), 1'b1, 5'(k + 20), 1'b1);
            tick();
        end
        drive_disp(32'h7f0, 5'd1, 1'b1, 5'd1, 1'b1, 5'd30, 1'b0);
        issue_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count_o); end
        checks++; if (disp_ready_o !== 1'b0) begin errors++; $display("FAIL full_disp_ready: got %b want 0", disp_ready_o); end
        tick();
        idle();
        issue_ready_i = 1'b0;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_after_issue: got %0d want 3", count_o); end
        checks++; if (disp_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_again: got %b want 1", disp_ready_o); end
        checks++; if (issue_pc_o !== 32'h704) begin errors++; $display("FAIL full_next_head: got pc=%h want 704", issue_pc_o); end
        tick();
        issue_ready_i = 1'b1;
        tick();
        tick();
        tick();
        @(negedge clk_i);
        checks++; if (issue_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL full_drain: got valid=%b count=%0d want 0/0", issue_valid_o, count_o); end
        tick();
        issue_ready_i = 1'b0;
    endtask

    task automatic test_flush_and_reset();
        for (int pass = 0; pass < 2; pass++) begin
            issue_ready_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
                drive_disp(32'h800 + k * 4, 5'(k + 1), 1'b1, 5'd0, 1'b1, 5'(k + 24), 1'b0);
                tick();
            end
            drive_disp(32'h8f0, 5'd1, 1'b1, 5'd1, 1'b1, 5'd31, 1'b0);
            if (pass == 0) flush_i = 1'b1;
            else reset_i = 1'b1;
            @(negedge clk_i);
            checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL clear%0d_pre_count: got %0d want 3", pass, count_o); end
            tick();
            idle();
            reset_i = 1'b0;
            @(negedge clk_i);
            checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL clear%0d_count: got %0d want 0", pass, count_o); end
            checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL clear%0d_valid: got %b want 0", pass, issue_valid_o); end
            checks++; if (disp_ready_o !== 1'b1) begin errors++; $display("FAIL clear%0d_disp_ready: got %b want 1", pass, disp_ready_o); end
            tick();
            issue_ready_i = 1'b1;
            @(negedge clk_i);
            checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL clear%0d_no_issue: got %b want 0", pass, issue_valid_o); end
            tick();
        end
        issue_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wakeup();
        test_bypass();
        test_out_of_order();
        test_shift_wakeup();
        test_stall_reselect();
        test_full();
        test_flush_and_reset();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_issues: got %0d outstanding, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
